// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester op/response handshake between a client (master) and the arbiter (slave)
interface alu_arbiter_if #(parameter int WORD_SIZE = 32);
  logic valid;
  logic ready;
  logic [2:0] op;
  logic [WORD_SIZE-1:0] a;
  logic [WORD_SIZE-1:0] b;
  logic resp_valid;
  logic resp_ready;
  logic [WORD_SIZE-1:0] resp_data;
  modport master(output valid, op, a, b, resp_ready, input ready, resp_valid, resp_data);
  modport slave(input valid, op, a, b, resp_ready, output ready, resp_valid, resp_data);
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered alu between two requesters with per-requester result buffers
module alu_arbiter #(parameter int WORD_SIZE = 32) (
  input logic clk,
  input logic reset,
  alu_arbiter_if.slave r0,
  alu_arbiter_if.slave r1,
  output logic [2:0] alu_control,
  output logic [WORD_SIZE-1:0] alu_in_1,
  output logic [WORD_SIZE-1:0] alu_in_2,
  input logic [WORD_SIZE-1:0] alu_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t st0, st1;
  logic last_grant, inflight_v, inflight_id, e0, e1, g0, g1;
  logic [WORD_SIZE-1:0] d0, d1;
  always_comb begin
    e0 = r0.valid && st0 == IDLE && !reset;
    e1 = r1.valid && st1 == IDLE && !reset;
    g0 = e0 && (!e1 || last_grant);
    g1 = e1 && (!e0 || !last_grant);
    alu_control = g0 ? r0.op : g1 ? r1.op : 3'b000;
    alu_in_1 = g0 ? r0.a : g1 ? r1.a : '0;
    alu_in_2 = g0 ? r0.b : g1 ? r1.b : '0;
  end
  assign r0.ready = g0;
  assign r1.ready = g1;
  assign r0.resp_valid = st0 == DONE;
  assign r1.resp_valid = st1 == DONE;
  assign r0.resp_data = d0;
  assign r1.resp_data = d1;
  always_ff @(posedge clk)
    if (reset) begin
      st0 <= IDLE;
      st1 <= IDLE;
      inflight_v <= 1'b0;
      inflight_id <= 1'b0;
      last_grant <= 1'b1;
      d0 <= '0;
      d1 <= '0;
    end else begin
      inflight_v <= g0 || g1;
      if (g0 || g1) begin
        inflight_id <= g1;
        last_grant <= g1;
      end
      if (inflight_v && !inflight_id) d0 <= alu_out;
      if (inflight_v && inflight_id) d1 <= alu_out;
      st0 <= g0 ? BUSY : st0 == BUSY ? DONE : (st0 == DONE && r0.resp_ready) ? IDLE : st0;
      st1 <= g1 ? BUSY : st1 == BUSY ? DONE : (st1 == DONE && r1.resp_ready) ? IDLE : st1;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural registered alu
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [7:0] G0 = 8'b01001001;
  localparam logic [7:0] G1 = 8'b10010010;
  localparam logic [7:0] G4 = 8'b10010010;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] alu_control;
  logic [W-1:0] alu_in_1, alu_in_2, alu_out;
  logic [W-1:0] q0[$], q1[$];
  int checks = 0;
  int errors = 0;
  alu_arbiter_if #(.WORD_SIZE(W)) r0();
  alu_arbiter_if #(.WORD_SIZE(W)) r1();
  alu_arbiter #(.WORD_SIZE(W)) dut (
    .clk(clk),
    .reset(reset),
    .r0(r0),
    .r1(r1),
    .alu_control(alu_control),
    .alu_in_1(alu_in_1),
    .alu_in_2(alu_in_2),
    .alu_out(alu_out)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b;
      3'd6: return a >> b;
      default: return $unsigned($signed(a) >>> b);
    endcase
  endfunction
  always @(posedge clk) alu_out <= reset ? '0 : alu_f(alu_control, alu_in_1, alu_in_2);
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    #3;
    if (r0.resp_valid && r0.resp_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r0_resp: got %h expected none", r0.resp_data);
      end else chk("r0_resp", r0.resp_data, q0.pop_front());
    end
    if (r1.resp_valid && r1.resp_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r1_resp: got %h expected none", r1.resp_data);
      end else chk("r1_resp", r1.resp_data, q1.pop_front());
    end
  end
  task automatic drain();
    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    @(negedge clk);
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    reset = 1'b1;
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
  endtask
  task automatic issue1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    @(negedge clk);
    r1.valid = 1'b1;
    r1.op = op;
    r1.a = a;
    r1.b = b;
    #1;
    for (int i = 0; i < 10 && !r1.ready; i++) begin
      @(negedge clk);
      #1;
    end
    chk("t6_r1_grant", r1.ready, 1);
    if (r1.ready) q1.push_back(exp);
    @(negedge clk);
    r1.valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    r0.valid = 1'b0; r0.op = 3'd0; r0.a = '0; r0.b = '0; r0.resp_ready = 1'b1;
    r1.valid = 1'b0; r1.op = 3'd0; r1.a = '0; r1.b = '0; r1.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    r0.valid = 1'b1; r0.op = 3'd1; r0.a = 32'd9;
    #1;
    chk("rst_r0_ready", r0.ready, 0);
    chk("rst_alu_ctrl", alu_control, 0);
    chk("rst_alu_in_1", alu_in_1, 0);
    @(negedge clk);
    reset = 1'b0;
    r0.valid = 1'b0;
    chk("rst_r0_resp_valid", r0.resp_valid, 0);
    chk("rst_r1_resp_valid", r1.resp_valid, 0);
    chk("rst_r0_resp_data", r0.resp_data, 0);
    chk("rst_r1_resp_data", r1.resp_data, 0);
    // test 1: single ADD, latency and pass-through
    @(negedge clk);
    r0.valid = 1'b1; r0.op = 3'd0; r0.a = 32'd5; r0.b = 32'd7;
    #1;
    chk("t1_r0_ready", r0.ready, 1);
    chk("t1_alu_in_1", alu_in_1, 5);
    chk("t1_alu_in_2", alu_in_2, 7);
    chk("t1_alu_ctrl", alu_control, 0);
    q0.push_back(32'd12);
    @(negedge clk);
    #1;
    chk("t1_busy_ready", r0.ready, 0);
    chk("t1_busy_resp_valid", r0.resp_valid, 0);
    @(negedge clk);
    r0.valid = 1'b0;
    chk("t1_resp_valid", r0.resp_valid, 1);
    chk("t1_resp_data", r0.resp_data, 12);
    drain();
    // test 2: simultaneous first requests, r0 wins the first tie
    rst_pulse();
    r0.valid = 1'b1; r0.op = 3'd1; r0.a = 32'd10; r0.b = 32'd3;
    r1.valid = 1'b1; r1.op = 3'd4; r1.a = 32'hF0; r1.b = 32'hFF;
    #1;
    chk("t2_r0_ready_c0", r0.ready, 1);
    chk("t2_r1_ready_c0", r1.ready, 0);
    q0.push_back(32'd7);
    @(negedge clk);
    r0.valid = 1'b0;
    #1;
    chk("t2_r1_ready_c1", r1.ready, 1);
    chk("t2_alu_in_1_c1", alu_in_1, 32'hF0);
    q1.push_back(32'h0F);
    @(negedge clk);
    r1.valid = 1'b0;
    chk("t2_r0_resp_valid_c2", r0.resp_valid, 1);
    chk("t2_r1_resp_valid_c2", r1.resp_valid, 0);
    @(negedge clk);
    chk("t2_r1_resp_valid_c3", r1.resp_valid, 1);
    drain();
    // test 3: both continuously valid
    rst_pulse();
    for (int i = 0; i < 8; i++) begin
      r0.valid = 1'b1; r0.op = 3'd0; r0.a = i; r0.b = 32'd100;
      r1.valid = 1'b1; r1.op = 3'd1; r1.a = 32'd1000; r1.b = i;
      #1;
      chk("t3_r0_ready", r0.ready, G0[i]);
      chk("t3_r1_ready", r1.ready, G1[i]);
      if (G0[i]) q0.push_back(i + 100);
      if (G1[i]) q1.push_back(1000 - i);
      @(negedge clk);
    end
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    drain();
    // test 4: backpressure on r0 does not stall r1
    rst_pulse();
    r0.valid = 1'b1; r0.op = 3'd0; r0.a = 32'd1; r0.b = 32'd2; r0.resp_ready = 1'b0;
    #1;
    chk("t4_r0_ready", r0.ready, 1);
    q0.push_back(32'd3);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      r1.valid = 1'b1; r1.op = 3'd1; r1.a = 32'd50; r1.b = i;
      #1;
      chk("t4_r0_blocked", r0.ready, 0);
      chk("t4_r1_ready", r1.ready, G4[i]);
      if (G4[i]) q1.push_back(50 - i);
      if (i >= 2) begin
        chk("t4_r0_resp_valid", r0.resp_valid, 1);
        chk("t4_r0_hold", r0.resp_data, 3);
      end
    end
    @(negedge clk);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    r0.resp_ready = 1'b1;
    drain();
    // test 5: reset mid-op discards the in-flight result
    rst_pulse();
    r0.valid = 1'b1; r0.op = 3'd0; r0.a = 32'd9; r0.b = 32'd9;
    #1;
    chk("t5_r0_ready", r0.ready, 1);
    @(negedge clk);
    reset = 1'b1;
    r0.valid = 1'b0;
    r1.valid = 1'b1; r1.op = 3'd1; r1.a = 32'd77; r1.b = 32'd1;
    #1;
    chk("t5_rst_r1_ready", r1.ready, 0);
    chk("t5_rst_alu_ctrl", alu_control, 0);
    chk("t5_rst_alu_in_1", alu_in_1, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("t5_r0_resp_valid", r0.resp_valid, 0);
    chk("t5_r0_resp_data", r0.resp_data, 0);
    r0.valid = 1'b1; r0.op = 3'd0; r0.a = 32'd2; r0.b = 32'd3;
    r1.valid = 1'b1; r1.op = 3'd0; r1.a = 32'd4; r1.b = 32'd4;
    #1;
    chk("t5_tie_r0", r0.ready, 1);
    chk("t5_tie_r1", r1.ready, 0);
    q0.push_back(32'd5);
    @(negedge clk);
    r0.valid = 1'b0;
    #1;
    chk("t5_r1_next", r1.ready, 1);
    q1.push_back(32'd8);
    @(negedge clk);
    r1.valid = 1'b0;
    drain();
    // test 6: shifts pass through unmodified
    issue1(3'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    issue1(3'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    issue1(3'd5, 32'd1, 32'd31, 32'h8000_0000);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
